// File: rtl/mandel_iter_ctrl_if.sv
// Bundle between the Mandelbrot iteration controller and its environment:
// the pixel scheduler side (start/c/max_iter in, busy/done/iter/escaped out)
// and the shared serial multiplier side (operands/start out, product/finished in).
// master = environment (scheduler + multiplier), slave = controller.
interface mandel_iter_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int ITER_W = 6
);
  logic                      start;
  logic signed [WIDTH-1:0]   cr;
  logic signed [WIDTH-1:0]   ci;
  logic [ITER_W-1:0]         max_iter;
  logic                      busy;
  logic                      done;
  logic [ITER_W-1:0]         iter;
  logic                      escaped;
  logic signed [WIDTH-1:0]   mul_x;
  logic signed [WIDTH-1:0]   mul_y;
  logic                      mul_start;
  logic signed [2*WIDTH-1:0] mul_out;
  logic                      mul_finished;
  logic                      mul_rst_n;

  modport master (
    output start, cr, ci, max_iter, mul_out, mul_finished,
    input  busy, done, iter, escaped, mul_x, mul_y, mul_start, mul_rst_n
  );

  modport slave (
    input  start, cr, ci, max_iter, mul_out, mul_finished,
    output busy, done, iter, escaped, mul_x, mul_y, mul_start, mul_rst_n
  );
endinterface

// File: rtl/mandel_iter_ctrl.sv
// Escape-time iteration controller for one Mandelbrot pixel. Time-shares one
// serial multiplier for x*x, y*y and x*y, then tests |z|^2 and updates z.
//
// state  | meaning
// IDLE   | waiting for start; result of the last pixel is held
// ISS_XX | pulse mul_start with operands (x,x)
// WT_XX  | wait for the multiplier, capture xx
// ISS_YY | pulse mul_start with operands (y,y)
// WT_YY  | wait for the multiplier, capture yy
// ISS_XY | pulse mul_start with operands (x,y)
// WT_XY  | wait for the multiplier, capture xy
// UPDATE | escape / limit / overflow decision, otherwise step z
module mandel_iter_ctrl #(
  parameter int WIDTH  = 8,
  parameter int FRAC   = WIDTH - 3,
  parameter int ITER_W = 6
) (
  input logic               clk,
  input logic               rst,
  mandel_iter_ctrl_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int EW = 2 * WIDTH + 1;
  localparam int NW = WIDTH + 3;
  localparam logic signed [EW-1:0] ESC_LIM = EW'(4 << (2 * FRAC));

  typedef enum logic [2:0] {
    IDLE, ISS_XX, WT_XX, ISS_YY, WT_YY, ISS_XY, WT_XY, UPDATE
  } state_t;

  state_t state_q, state_d;

  logic signed [WIDTH-1:0] cr_q, ci_q, x_q, y_q, x_d, y_d;
  logic signed [WIDTH-1:0] mul_x_q, mul_y_q, mul_x_d, mul_y_d;
  logic signed [PW-1:0]    xx_q, yy_q, xy_q;
  logic [ITER_W-1:0]       max_q, iter_q;
  logic                    esc_q, done_q;

  logic signed [EW-1:0]    mag;
  logic signed [PW-1:0]    xx_sh, yy_sh, xy_sh;
  logic signed [NW-1:0]    x_new, y_new;
  logic                    esc_mag, at_limit, ovf, finish;

  // |z|^2 and the candidate next z, all from the products captured this iteration
  assign mag      = EW'(xx_q) + EW'(yy_q);
  assign esc_mag  = (mag >= ESC_LIM);
  assign at_limit = (iter_q == max_q);
  assign xx_sh    = xx_q >>> FRAC;
  assign yy_sh    = yy_q >>> FRAC;
  assign xy_sh    = xy_q >>> FRAC;
  assign x_new    = NW'(xx_sh) - NW'(yy_sh) + NW'(cr_q);
  assign y_new    = (NW'(xy_sh) <<< 1) + NW'(ci_q);
  // a next z that does not fit WIDTH counts as escaped instead of wrapping
  assign ovf      = (x_new[NW-1:WIDTH-1] != {(NW-WIDTH+1){x_new[WIDTH-1]}}) ||
                    (y_new[NW-1:WIDTH-1] != {(NW-WIDTH+1){y_new[WIDTH-1]}});
  assign finish   = esc_mag || at_limit || ovf;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = ISS_XX;
      ISS_XX:  state_d = WT_XX;
      WT_XX:   if (bus.mul_finished) state_d = ISS_YY;
      ISS_YY:  state_d = WT_YY;
      WT_YY:   if (bus.mul_finished) state_d = ISS_XY;
      ISS_XY:  state_d = WT_XY;
      WT_XY:   if (bus.mul_finished) state_d = UPDATE;
      UPDATE:  state_d = finish ? IDLE : ISS_XX;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.mul_start = (state_q == ISS_XX) || (state_q == ISS_YY) || (state_q == ISS_XY);
  end

  // Next z and next multiplier operands; operands load on entry to ISS_* and
  // then hold through the WT state since the multiplier re-reads them every cycle
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    mul_x_d = mul_x_q;
    mul_y_d = mul_y_q;
    if (state_q == IDLE && bus.start) begin
      x_d = '0;
      y_d = '0;
    end else if (state_q == UPDATE && !finish) begin
      x_d = x_new[WIDTH-1:0];
      y_d = y_new[WIDTH-1:0];
    end
    unique case (state_d)
      ISS_XX:  begin mul_x_d = x_d; mul_y_d = x_d; end
      ISS_YY:  begin mul_x_d = y_d; mul_y_d = y_d; end
      ISS_XY:  begin mul_x_d = x_d; mul_y_d = y_d; end
      default: ;
    endcase
  end

  // Datapath registers: pixel capture, product capture, iteration result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cr_q    <= '0;
      ci_q    <= '0;
      max_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      xx_q    <= '0;
      yy_q    <= '0;
      xy_q    <= '0;
      iter_q  <= '0;
      esc_q   <= 1'b0;
      done_q  <= 1'b0;
      mul_x_q <= '0;
      mul_y_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      mul_x_q <= mul_x_d;
      mul_y_q <= mul_y_d;
      done_q  <= (state_q == UPDATE) && finish;
      unique case (state_q)
        IDLE: if (bus.start) begin
          cr_q   <= bus.cr;
          ci_q   <= bus.ci;
          max_q  <= bus.max_iter;
          iter_q <= '0;
          esc_q  <= 1'b0;
        end
        WT_XX: if (bus.mul_finished) xx_q <= bus.mul_out;
        WT_YY: if (bus.mul_finished) yy_q <= bus.mul_out;
        WT_XY: if (bus.mul_finished) xy_q <= bus.mul_out;
        UPDATE: begin
          if (esc_mag) begin
            esc_q <= 1'b1;
          end else if (at_limit) begin
            esc_q <= 1'b0;
          end else begin
            iter_q <= iter_q + ITER_W'(1);
            if (ovf) esc_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.done      = done_q;
  assign bus.iter      = iter_q;
  assign bus.escaped   = esc_q;
  assign bus.mul_x     = mul_x_q;
  assign bus.mul_y     = mul_y_q;
  assign bus.mul_rst_n = ~rst;
endmodule
